mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
Debug-side reader for the pipeline's data RAM, the opposite end of the MEM stage's write path. After the processor halts, it sequentially reads a window of data-memory words through the RAM's second (read-only) port. Each word is serialized MSB-byte-first onto a valid/ready byte stream that feeds the UART transmitter of the debug unit. The host can therefore inspect everything the program stored.

Parameters:
ADDR_W, 13, data-RAM word-address width; matches RAM depth 2^13 words
DATA_W, 32, RAM word width; fixed at 32, 4 bytes per word

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a dump; sampled only in IDLE
base_addr  in  ADDR_W  first word address; latched on accepted start
word_count  in  ADDR_W+1  number of words to dump, 0..2^ADDR_W; latched on accepted start
mem_addr  out  ADDR_W  registered read address to RAM port B
mem_rdata  in  DATA_W  RAM port B data; valid one cycle after mem_addr is presented
tx_data  out  8  byte to transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the dump completes

Behaviour:
- Reset values: mem_addr=0, tx_data=0, tx_valid=0, busy=0, done=0; state=IDLE; internal counters=0.
- States: IDLE, RD, WT, SEND, FIN.
- IDLE:
  - On start with word_count!=0: latch cur_addr=base_addr and remaining=word_count, drive mem_addr=base_addr, go to RD.
  - On start with word_count==0: go directly to FIN (no bytes sent).
- RD: address held; go to WT. The RAM registers its output at the end of this cycle.
- WT: capture mem_rdata into a 32-bit shift register, set byte_idx=0, set tx_data=rdata[31:24], set tx_valid=1, go to SEND.
- SEND: tx_valid=1, and tx_data stays stable until the handshake completes. On tx_valid && tx_ready:
  - byte_idx<3: shift left 8, increment byte_idx, present the next byte. There is no bubble between bytes.
  - byte_idx==3: drop tx_valid, decrement remaining, increment cur_addr modulo 2^ADDR_W (wraps to 0 after 2^ADDR_W-1), drive mem_addr=cur_addr+1. Go to RD if remaining-1!=0, else go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge k gives tx_valid=1 from cycle k+3. Each subsequent word costs 2 idle cycles (RD, WT) after its predecessor's last byte handshake.
- A start pulse while busy is ignored, with no effect on latched values.
- When tx_ready is held low, the block stalls indefinitely in SEND with no data loss.
- Reset asserted mid-dump: on the next edge, all outputs return to their reset values, any partial word is discarded, and done does not pulse.
- word_count=2^ADDR_W dumps the whole RAM, wrapping once if base_addr!=0.
- base_addr and word_count are ignored after latch.

Optional Feature:
DUMP_CHECKSUM_EN
- Defined:
  - An 8-bit running sum (mod 256) of every byte handshaken is kept. It is cleared on accepted start.
  - After the last word's 4th byte, the block enters an extra state CSUM that presents the sum on tx_data with tx_valid=1 until handshake, then goes to FIN.
  - word_count==0 still sends a single checksum byte 0x00.
- Undefined: no CSUM state, no sum register; behaviour exactly as above.

Decomposition:
- Shared package mips_debug_pkg:
  - state encoding constants (IDLE=0..FIN=4, CSUM=5)
  - BYTES_PER_WORD=4
  - DUMP_ADDR_W=13
- One natural sub-module: word_serializer (32-bit load, 8-bit valid/ready output, last-byte flag). The FSM in mem_dump_reader handles addressing and counting only.

Test Plan:
- RAM[5]=0x11223344, start with base=5 and count=1, tx_ready=1 → tx_valid rises 3 cycles after start; bytes 0x11,0x22,0x33,0x44 on consecutive cycles; done pulses once; mem_addr=5 during read.
- RAM[0..2]=0xA0A1A2A3,0xB0B1B2B3,0xC0C1C2C3, count=3, tx_ready toggling 1/0 each cycle → 12 bytes in order with no loss or duplication; tx_data stable while stalled.
- base=0x1FFF, count=2, RAM[0x1FFF]=0xDEADBEEF, RAM[0]=0x01020304 → DE AD BE EF 01 02 03 04; mem_addr wraps to 0.
- count=0 → no tx_valid, done pulses 2 cycles after start (FIN); with DUMP_CHECKSUM_EN, a single byte 0x00 is sent before done.
- Reset asserted during the 2nd byte of a 2-word dump → next cycle tx_valid=0, busy=0, no done; a new start then dumps correctly from base.
- DUMP_CHECKSUM_EN, word 0x01020304 → trailing byte 0x0A; a start pulse during busy is ignored.

Source files
------------

// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg
// Shared constants and the state encoding for the debug-side memory dump
// reader (mem_dump_reader) and its byte serializer (word_serializer).
// ST_CSUM is only reachable when the design is built with DUMP_CHECKSUM_EN.
package mips_debug_pkg;

  localparam int DUMP_ADDR_W    = 13;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4,
    ST_CSUM = 3'd5
  } dump_state_e;

endpackage

// File: rtl/word_serializer.sv
// word_serializer
// Takes a 32-bit word and presents it MSB byte first on a valid/ready byte
// stream, with no bubble between the bytes of one word.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   load           load load_data as a full 4-byte word
//   load_byte      load load_data[7:0] as a single, final byte
//   load_data      word to serialize
//   tx_data        current byte (top byte of the shift register)
//   tx_valid       tx_data is valid
//   tx_ready       downstream accepts on tx_valid && tx_ready
//   last_fire      handshake of the final byte of the loaded item
module word_serializer
  import mips_debug_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        load_byte,
  input  logic [31:0] load_data,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_fire
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        fire;

  always_comb begin
    fire      = valid_q & tx_ready;
    last_fire = fire & (idx_q == LAST_IDX);

    shreg_d = shreg_q;
    idx_d   = idx_q;
    valid_d = valid_q;

    // A load may coincide with the final handshake of the previous item;
    // the load wins because that byte has already been consumed.
    if (load) begin
      shreg_d = load_data;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (load_byte) begin
      // Single byte is placed on top and marked as last.
      shreg_d = {load_data[7:0], 24'h000000};
      idx_d   = LAST_IDX;
      valid_d = 1'b1;
    end else if (fire) begin
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
      end else begin
        shreg_d = {shreg_q[23:0], 8'h00};
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign tx_data  = shreg_q[31:24];
  assign tx_valid = valid_q;

endmodule

// File: rtl/mem_dump_reader.sv
// mem_dump_reader
// Reads a window of data-RAM words through the RAM's read-only port after
// the processor halts and streams each word MSB byte first to the debug UART.
// Build option: DUMP_CHECKSUM_EN appends an 8-bit sum of all sent bytes.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               dump request, honoured only when idle
//   base_addr           first word address (latched on accepted start)
//   word_count          words to dump, 0..2^ADDR_W (latched on accepted start)
//   mem_addr            registered RAM read address
//   mem_rdata           RAM data, one cycle after mem_addr
//   tx_data, tx_valid   byte stream to the transmitter
//   tx_ready            transmitter accept
//   busy                high whenever not idle
//   done                one-cycle pulse at the end of a dump
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// RD      | mem_addr presented, RAM registers the word at end of cycle
// WT      | RAM word available, loaded into the serializer
// SEND    | serializer streaming the 4 bytes of the current word
// CSUM    | checksum byte being sent (DUMP_CHECKSUM_EN only)
// FIN     | dump finished; done pulses in the following cycle
module mem_dump_reader
  import mips_debug_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              ser_load;
  logic              ser_load_byte;
  logic [DATA_W-1:0] ser_data;
  logic              ser_last_fire;

  word_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_byte (ser_load_byte),
    .load_data (ser_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last_fire (ser_last_fire)
  );

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    mem_addr_d    = mem_addr_q;
    done_d        = 1'b0;
    ser_load      = 1'b0;
    ser_load_byte = 1'b0;
    ser_data      = mem_rdata;
`ifdef DUMP_CHECKSUM_EN
    csum_d = csum_q;
    // Only data bytes are summed, never the checksum byte itself.
    if (state_q == ST_SEND && tx_valid && tx_ready) csum_d = csum_q + tx_data;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef DUMP_CHECKSUM_EN
          csum_d = 8'h00;
`endif
          if (word_count != '0) begin
            cur_addr_d  = base_addr;
            remaining_d = word_count;
            mem_addr_d  = base_addr;
            state_d     = ST_RD;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            ser_load_byte = 1'b1;
            ser_data      = '0;
            state_d       = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
      ST_RD: state_d = ST_WT;
      ST_WT: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (ser_last_fire) begin
          remaining_d = remaining_q - CNT_ONE;
          // Natural ADDR_W-bit overflow gives the wrap to address 0.
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          mem_addr_d  = cur_addr_q + ADDR_W'(1);
          if (remaining_q != CNT_ONE) begin
            state_d = ST_RD;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            ser_load_byte = 1'b1;
            ser_data      = {{(DATA_W-8){1'b0}}, csum_d};
            state_d       = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (ser_last_fire) state_d = ST_FIN;
      end
`endif
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      mem_addr_q  <= mem_addr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Testbench for mem_dump_reader: behavioural RAM plus an expected byte
// stream built directly from RAM contents, compared against what the
// transmitter side actually accepts.
module tb_mem_dump_reader;

  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mem_dump_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  logic [31:0] ram [DEPTH];
  always @(posedge clk) mem_rdata <= ram[mem_addr];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter-side monitor, sampled mid-cycle.
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int         done_cnt;
  int         done_cyc;
  int         first_valid_cyc;
  bit         stall_pend = 1'b0;
  logic [7:0] held;

  always @(negedge clk) begin
    if (stall_pend) chk("stall_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, held});
    stall_pend = tx_valid && !tx_ready && !reset;
    held       = tx_data;
    if (tx_valid && tx_ready && !reset) got.push_back(tx_data);
    if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int rdy_mode = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic build_exp(input int base, input int cnt);
    logic [7:0]  sum;
    logic [31:0] w;
    exp_q.delete();
    sum = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      w = ram[(base + i) % DEPTH];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        sum = sum + w[b*8 +: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic run_dump(input int base, input int cnt, input int mode, input bit poke);
    int s;
    int budget;
    int nbad;
    rdy_mode = mode;
    got.delete();
    done_cnt        = 0;
    first_valid_cyc = -1;
    build_exp(base, cnt);
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = AW'(base);
    word_count = (AW+1)'(cnt);
    s = cyc;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = AW'($urandom);
    word_count = (AW+1)'($urandom);
    @(negedge clk);
    if (cnt != 0) chk("rd_addr", 64'(mem_addr), 64'(base));
    if (poke && cnt != 0) begin
      @(posedge clk); #1;
      start      = 1'b1;
      base_addr  = AW'($urandom);
      word_count = 1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    budget = cnt * 40 + 60;
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    chk("done_seen", 64'(done_cnt), 64'd1);
    if (cnt != 0) chk("tx_latency", 64'(first_valid_cyc - s), 64'd3);
`ifndef DUMP_CHECKSUM_EN
    if (cnt == 0) begin
      chk("no_valid", 64'(first_valid_cyc), 64'(-1));
      chk("done_latency", 64'(done_cyc - s), 64'd2);
    end
`endif
    repeat (3) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("byte_count", 64'(got.size()), 64'(exp_q.size()));
    if (exp_q.size() <= 32) begin
      for (int i = 0; i < exp_q.size(); i++)
        chk($sformatf("byte%0d", i), (i < got.size()) ? 64'(got[i]) : 64'hxx, 64'(exp_q[i]));
    end else begin
      nbad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
      chk("stream_bad_bytes", 64'(nbad), 64'd0);
    end
    if (cnt != 0) chk("end_addr", 64'(mem_addr), 64'((base + cnt) % DEPTH));
  endtask

  task automatic reset_mid_dump();
    rdy_mode = 0;
    got.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = AW'(12'h040);
    word_count = 2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && got.size() < 1; i++) @(negedge clk);
    chk("mid_first_byte", 64'(got.size()), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    run_dump(12'h040, 2, 0, 0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    tx_ready   = 1'b1;
    done_cnt   = 0;
    done_cyc   = 0;
    first_valid_cyc = -1;
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_tx_data", 64'(tx_data), 64'd0);
    chk("reset_tx_valid", 64'(tx_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    ram[5] = 32'h11223344;
    run_dump(5, 1, 0, 0);

    ram[0] = 32'hA0A1A2A3;
    ram[1] = 32'hB0B1B2B3;
    ram[2] = 32'hC0C1C2C3;
    run_dump(0, 3, 1, 0);

    ram[DEPTH-1] = 32'hDEADBEEF;
    ram[0]       = 32'h01020304;
    run_dump(DEPTH - 1, 2, 0, 1);

    run_dump(100, 0, 0, 0);

    reset_mid_dump();

    ram[9] = 32'h01020304;
    run_dump(9, 1, 2, 1);

    for (int t = 0; t < 8; t++)
      run_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 5)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    run_dump(int'($urandom_range(1, DEPTH - 1)), DEPTH, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
